// File: rtl/uart_core_if.sv
// Handshake and serial signals of uart_core. The core uses the slave modport;
// the user of the core (a top level or a bench) uses the master modport.
interface uart_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 en;
    logic                 loopback;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 tx_busy;

    modport master (
        output en, loopback, tx_data, tx_valid, rx,
        input  tx_ready, tx, rx_data, rx_valid, parity_err, frame_err, tx_busy
    );

    modport slave (
        input  en, loopback, tx_data, tx_valid, rx,
        output tx_ready, tx, rx_data, rx_valid, parity_err, frame_err, tx_busy
    );
endinterface

// File: rtl/uart_core.sv
// Parametrised UART transceiver: valid/ready TX path, pulsed RX path with
// parity/framing flags, and an internal TX->RX loopback for self-test.
module uart_core #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    uart_core_if.slave bus
);
    localparam int            CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);
    localparam bit            HAS_PARITY = (PARITY != 0);

    function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_DONE} rx_state_t;

    tx_state_t            r_tx_state;
    logic [CW-1:0]        r_tx_cnt;
    logic [3:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx_line;
    logic                 r_tx_busy;
    logic                 w_tx_ready;
    logic                 w_tx_bit_end;

    rx_state_t            r_rx_state;
    logic [CW-1:0]        r_rx_cnt;
    logic [3:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_bit;
    logic                 r_rx_ferr_acc;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_perr;
    logic                 r_rx_ferr;
    logic                 w_rx_bit_end;

    logic                 r_lb_sel;
    logic                 r_sync_p0;
    logic                 r_sync_p1;
    logic                 w_rx_src;

    assign w_tx_ready   = bus.en && (r_tx_state == TX_IDLE);
    assign w_tx_bit_end = (r_tx_cnt == CNT_LAST);
    assign w_rx_bit_end = (r_rx_cnt == CNT_LAST);
    assign w_rx_src     = r_lb_sel ? r_tx_line : bus.rx;

    // Transmit FSM: the line value is registered one bit ahead of each state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_line  <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_cnt <= '0;
                    if (bus.tx_valid && w_tx_ready) begin
                        r_tx_shift <= bus.tx_data;
                        r_tx_par   <= f_parity(bus.tx_data);
                        r_tx_line  <= 1'b0;
                        r_tx_busy  <= 1'b1;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_line  <= r_tx_shift[0];
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_tx_bit_end) begin
                        r_tx_shift <= r_tx_shift >> 1;
                        if (r_tx_bit == DATA_LAST) begin
                            r_tx_bit <= '0;
                            if (HAS_PARITY) begin
                                r_tx_line  <= r_tx_par;
                                r_tx_state <= TX_PARITY;
                            end else begin
                                r_tx_line  <= 1'b1;
                                r_tx_state <= TX_STOP;
                            end
                        end else begin
                            r_tx_bit  <= r_tx_bit + 1'b1;
                            r_tx_line <= r_tx_shift[1];
                        end
                    end
                end
                TX_PARITY: begin
                    if (w_tx_bit_end) begin
                        r_tx_line  <= 1'b1;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (w_tx_bit_end) begin
                        if (r_tx_bit == STOP_LAST) begin
                            r_tx_busy  <= 1'b0;
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx_line  <= 1'b1;
                    r_tx_busy  <= 1'b0;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // Input synchroniser; the loopback source only switches while both paths are idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lb_sel  <= 1'b0;
            r_sync_p0 <= 1'b1;
            r_sync_p1 <= 1'b1;
        end else begin
            if (r_tx_state == TX_IDLE && r_rx_state == RX_IDLE) begin
                r_lb_sel <= bus.loopback;
            end
            r_sync_p0 <= w_rx_src;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Receive FSM: samples at mid-bit, counted from the half-bit start check.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state    <= RX_IDLE;
            r_rx_cnt      <= '0;
            r_rx_bit      <= '0;
            r_rx_ferr_acc <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_perr     <= 1'b0;
            r_rx_ferr     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_cnt   <= w_rx_bit_end ? '0 : r_rx_cnt + 1'b1;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    if (bus.en && !r_sync_p1) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == CNT_HALF) begin
                        r_rx_cnt      <= '0;
                        r_rx_bit      <= '0;
                        r_rx_ferr_acc <= 1'b0;
                        r_rx_state    <= r_sync_p1 ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_shift <= {r_sync_p1, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == DATA_LAST) begin
                            r_rx_bit   <= '0;
                            r_rx_state <= HAS_PARITY ? RX_PARITY : RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (w_rx_bit_end) begin
                        r_rx_par_bit <= r_sync_p1;
                        r_rx_state   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (w_rx_bit_end) begin
                        if (r_rx_bit == STOP_LAST) begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                            r_rx_perr  <= HAS_PARITY && (r_rx_par_bit != f_parity(r_rx_shift));
                            r_rx_ferr  <= r_rx_ferr_acc | ~r_sync_p1;
                            r_rx_state <= RX_DONE;
                        end else begin
                            r_rx_ferr_acc <= r_rx_ferr_acc | ~r_sync_p1;
                            r_rx_bit      <= r_rx_bit + 1'b1;
                        end
                    end
                end
                RX_DONE: begin
                    r_rx_cnt   <= '0;
                    r_rx_state <= RX_IDLE;
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready   = w_tx_ready;
    assign bus.tx         = r_lb_sel | r_tx_line;
    assign bus.tx_busy    = r_tx_busy;
    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.parity_err = r_rx_perr;
    assign bus.frame_err  = r_rx_ferr;
endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: an 8E1 instance (A) and a 5O2 instance (B), both at 16 clocks per bit,
// checked against a frame-level model of the serial format.
module tb_uart_core;
    localparam int C = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_core_if #(.DATA_BITS(8)) ifa ();
    uart_core_if #(.DATA_BITS(5)) ifb ();

    uart_core #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    uart_core #(.CLKS_PER_BIT(C), .DATA_BITS(5), .PARITY(1), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    // Observed events, collected away from the active edge.
    logic [10:0] qa_rx[$];
    logic [10:0] qb_rx[$];
    int          qa_busy[$];
    int          qb_busy[$];
    int          qa_acc[$];
    int          run_a = 0;
    int          run_b = 0;
    logic        lb_low_a = 1'b0;

    always @(negedge clk) begin
        if (ifa.rx_valid) qa_rx.push_back({1'b0, ifa.rx_data, ifa.parity_err, ifa.frame_err});
        if (ifb.rx_valid) qb_rx.push_back({4'b0, ifb.rx_data, ifb.parity_err, ifb.frame_err});
        if (ifa.tx_busy) run_a++;
        else if (run_a != 0) begin qa_busy.push_back(run_a); run_a = 0; end
        if (ifb.tx_busy) run_b++;
        else if (run_b != 0) begin qb_busy.push_back(run_b); run_b = 0; end
        if (!rst && ifa.tx_valid && ifa.tx_ready) qa_acc.push_back(cyc);
        if (ifa.loopback && !ifa.tx) lb_low_a = 1'b1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Frame-level reference model.
    logic fbits[$];

    function automatic logic ref_parity(input int p, input logic [8:0] d, input int db);
        int ones = 0;
        for (int i = 0; i < db; i++) ones += int'(d[i]);
        return (p == 2) ? logic'(ones % 2) : logic'((ones + 1) % 2);
    endfunction

    function automatic int frame_len(input int db, input int p, input int sb);
        return C * (1 + db + ((p != 0) ? 1 : 0) + sb);
    endfunction

    task automatic build_frame(input logic [8:0] d, input int db, input int p, input int sb);
        fbits.delete();
        fbits.push_back(1'b0);
        for (int i = 0; i < db; i++) fbits.push_back(d[i]);
        if (p != 0) fbits.push_back(ref_parity(p, d, db));
        for (int i = 0; i < sb; i++) fbits.push_back(1'b1);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rx_count(input int which);
        return (which == 0) ? qa_rx.size() : qb_rx.size();
    endfunction

    task automatic wait_rx(input int which, input int n, input int budget);
        int k = 0;
        while (rx_count(which) < n && k < budget) begin tick(); k++; end
        check($sformatf("rx_count%0d", which), rx_count(which), n);
    endtask

    task automatic send(input int which, input logic [8:0] d);
        int k = 0;
        while (!((which == 0) ? ifa.tx_ready : ifb.tx_ready) && k < 1000) begin tick(); k++; end
        check($sformatf("tx_ready%0d", which), (which == 0) ? ifa.tx_ready : ifb.tx_ready, 1);
        if (which == 0) begin ifa.tx_data = d[7:0]; ifa.tx_valid = 1'b1; end
        else begin ifb.tx_data = d[4:0]; ifb.tx_valid = 1'b1; end
        tick();
        ifa.tx_valid = 1'b0;
        ifb.tx_valid = 1'b0;
    endtask

    // Called right after the accepting edge; samples tx at the middle of every bit.
    task automatic check_tx_wave(input int which, input logic [8:0] d);
        if (which == 0) build_frame(d, 8, 2, 1);
        else build_frame(d, 5, 1, 2);
        repeat (C / 2) tick();
        for (int i = 0; i < fbits.size(); i++) begin
            check($sformatf("txbit%0d_%0d", which, i), (which == 0) ? ifa.tx : ifb.tx, fbits[i]);
            repeat (C) tick();
        end
    endtask

    task automatic drive_rx_a(input logic [7:0] d, input logic flip_par, input logic bad_stop);
        build_frame({1'b0, d}, 8, 2, 1);
        if (flip_par) fbits[9] = ~fbits[9];
        if (bad_stop) fbits[10] = 1'b0;
        for (int i = 0; i < fbits.size(); i++) begin
            ifa.rx = fbits[i];
            repeat (C) tick();
        end
        ifa.rx = 1'b1;
        repeat (2 * C) tick();
    endtask

    initial begin
        logic [7:0]  w;
        logic [4:0]  w5;
        logic        fp;
        logic        bs;
        logic [7:0]  words[$];
        logic [7:0]  bb[3];

        rst = 1'b1;
        ifa.en = 1'b0; ifa.loopback = 1'b0; ifa.tx_data = '0; ifa.tx_valid = 1'b0; ifa.rx = 1'b1;
        ifb.en = 1'b0; ifb.loopback = 1'b0; ifb.tx_data = '0; ifb.tx_valid = 1'b0; ifb.rx = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_tx", ifa.tx, 1);
        check("rst_busy", ifa.tx_busy, 0);
        check("rst_rx_data", ifa.rx_data, 0);
        check("rst_rx_valid", ifa.rx_valid, 0);
        check("rst_perr", ifa.parity_err, 0);
        check("rst_ferr", ifa.frame_err, 0);
        check("rst_ready_en0", ifa.tx_ready, 0);
        rst = 1'b0;
        tick();

        // en=0 blocks new frames and tx_valid is ignored
        ifa.tx_valid = 1'b1; ifa.tx_data = 8'h77;
        repeat (5) tick();
        check("en0_busy", ifa.tx_busy, 0);
        check("en0_tx", ifa.tx, 1);
        ifa.tx_valid = 1'b0;
        ifa.en = 1'b1; ifb.en = 1'b1;
        #1;
        check("en1_ready", ifa.tx_ready, 1);

        // Loopback single word 0xA5
        ifa.loopback = 1'b1;
        repeat (2) tick();
        qa_rx.delete(); qa_busy.delete();
        send(0, 9'h0A5);
        wait_rx(0, 1, 400);
        repeat (10) tick();
        check("lb_busy_cnt", qa_busy.size(), 1);
        if (qa_busy.size() > 0) check("lb_busy_len", qa_busy[0], frame_len(8, 2, 1));
        if (qa_rx.size() > 0) check("lb_rx_a5", qa_rx[0], {9'h0A5, 1'b0, 1'b0});
        check("lb_pin_high", lb_low_a, 0);

        // Back-to-back with tx_valid held high
        qa_rx.delete(); qa_acc.delete();
        bb[0] = 8'h00; bb[1] = 8'hFF; bb[2] = 8'h3C;
        ifa.tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int k = 0;
            ifa.tx_data = bb[i];
            while (!ifa.tx_ready && k < 500) begin tick(); k++; end
            tick();
        end
        ifa.tx_valid = 1'b0;
        wait_rx(0, 3, 800);
        check("b2b_acc_cnt", qa_acc.size(), 3);
        if (qa_acc.size() == 3) begin
            check("b2b_gap1", qa_acc[1] - qa_acc[0], frame_len(8, 2, 1) + 1);
            check("b2b_gap2", qa_acc[2] - qa_acc[1], frame_len(8, 2, 1) + 1);
        end
        for (int i = 0; i < 3 && i < qa_rx.size(); i++)
            check($sformatf("b2b_rx%0d", i), qa_rx[i], {1'b0, bb[i], 1'b0, 1'b0});

        // Random loopback words
        qa_rx.delete(); words.delete();
        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            words.push_back(w);
            send(0, {1'b0, w});
        end
        wait_rx(0, 6, 1500);
        for (int i = 0; i < 6 && i < qa_rx.size(); i++)
            check($sformatf("lb_rand%0d", i), qa_rx[i], {1'b0, words[i], 1'b0, 1'b0});

        // TX waveform on the pin
        ifa.loopback = 1'b0;
        repeat (3 * C) tick();
        qa_busy.delete();
        for (int i = 0; i < 3; i++) begin
            w = (i == 0) ? 8'hA5 : 8'($urandom);
            send(0, {1'b0, w});
            check_tx_wave(0, {1'b0, w});
        end
        repeat (4) tick();
        if (qa_busy.size() > 0) check("wave_busy_len", qa_busy[0], frame_len(8, 2, 1));

        // RX error injection from the pin
        qa_rx.delete();
        drive_rx_a(8'h5A, 1'b1, 1'b0);
        wait_rx(0, 1, 50);
        if (qa_rx.size() > 0) check("rx_perr_5a", qa_rx[0], {9'h05A, 1'b1, 1'b0});
        drive_rx_a(8'h5A, 1'b0, 1'b1);
        wait_rx(0, 2, 50);
        if (qa_rx.size() > 1) check("rx_ferr_5a", qa_rx[1], {9'h05A, 1'b0, 1'b1});
        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom); fp = 1'($urandom); bs = 1'($urandom);
            drive_rx_a(w, fp, bs);
            wait_rx(0, 3 + i, 50);
            if (qa_rx.size() > 2 + i) check($sformatf("rx_rand%0d", i), qa_rx[2 + i], {1'b0, w, fp, bs});
        end

        // Short glitch rejected, then a clean 0x81
        qa_rx.delete();
        ifa.rx = 1'b0;
        repeat (4) tick();
        ifa.rx = 1'b1;
        repeat (3 * C) tick();
        check("glitch_no_rx", qa_rx.size(), 0);
        drive_rx_a(8'h81, 1'b0, 1'b0);
        wait_rx(0, 1, 50);
        if (qa_rx.size() > 0) check("glitch_then_81", qa_rx[0], {9'h081, 1'b0, 1'b0});

        // Instance B: 5 data bits, odd parity, 2 stop bits
        qb_busy.delete();
        send(1, 9'h013);
        check_tx_wave(1, 9'h013);
        repeat (4) tick();
        check("b_busy_cnt", qb_busy.size(), 1);
        if (qb_busy.size() > 0) check("b_busy_len", qb_busy[0], frame_len(5, 1, 2));
        ifb.loopback = 1'b1;
        repeat (2) tick();
        qb_rx.delete(); words.delete();
        send(1, 9'h013);
        words.push_back(8'h13);
        for (int i = 0; i < 3; i++) begin
            w5 = 5'($urandom);
            words.push_back({3'b0, w5});
            send(1, {4'b0, w5});
        end
        wait_rx(1, 4, 1000);
        for (int i = 0; i < 4 && i < qb_rx.size(); i++)
            check($sformatf("b_lb%0d", i), qb_rx[i], {1'b0, words[i], 1'b0, 1'b0});

        // Reset mid-DATA on the pin
        send(0, 9'h000);
        repeat (3 * C) tick();
        check("mid_tx_low", ifa.tx, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_tx", ifa.tx, 1);
        check("rst_mid_busy", ifa.tx_busy, 0);

        // Reset mid-DATA in loopback: aborted frame never reaches RX
        ifa.loopback = 1'b1;
        repeat (3) tick();
        qa_rx.delete();
        send(0, {1'b0, 8'($urandom)});
        repeat (4 * C) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_lb_busy", ifa.tx_busy, 0);
        repeat (250) tick();
        check("rst_lb_no_rx", qa_rx.size(), 0);
        send(0, 9'h042);
        wait_rx(0, 1, 400);
        if (qa_rx.size() > 0) check("after_rst_42", qa_rx[0], {9'h042, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
